// File: rtl/div_10by5_pkg.sv
// Shared constants and FSM state type for the 10-by-5 restoring divider.
package div_pkg;
  localparam int DVD_W_C = 10;
  localparam int DVS_W_C = 5;
  localparam int STEPS   = 5;
  localparam int CNT_W   = 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_10by5_step.sv
// One restoring-division step: shift in the next dividend bit, subtract when it fits.
module div_step #(
  parameter int W = 5
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);
  logic [W:0] t;

  assign t = {rem_in, bit_in};
  assign q_bit = (t >= {1'b0, divisor});
  // rem_in < divisor keeps t - divisor inside W bits
  assign rem_out = q_bit ? W'(t - {1'b0, divisor}) : t[W-1:0];
endmodule

// File: rtl/div_10by5.sv
// Multi-cycle 10/5-bit unsigned divider: one quotient bit per cycle, with zero/overflow early-out.
module div_10by5
  import div_pkg::*;
#(
  parameter int DVD_W = DVD_W_C,
  parameter int DVS_W = DVS_W_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);
  state_t state, state_nxt;

  logic [DVS_W-1:0] rem_q, shf_q, dvs_q;
  logic [CNT_W-1:0] cnt;
  logic [DVS_W-1:0] rem_nxt;
  logic             q_bit;
  logic             accept, is_zero, is_ovf, last_step;

  assign accept    = start && (state != RUN);
  assign is_zero   = (divisor == '0);
  // high half >= divisor means the quotient needs more than DVS_W bits
  assign is_ovf    = (dividend[DVD_W-1:DVS_W] >= divisor);
  assign last_step = (cnt == CNT_W'(STEPS - 1));
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  div_step #(.W(DVS_W)) u_step (
    .rem_in  (rem_q),
    .bit_in  (shf_q[DVS_W-1]),
    .divisor (dvs_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (is_zero || is_ovf) ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      RUN:     if (last_step) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q       <= '0;
      shf_q       <= '0;
      dvs_q       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept) begin
      if (is_zero) begin
        quotient    <= '1;
        remainder   <= dividend[DVS_W-1:0];
        div_by_zero <= 1'b1;
        overflow    <= 1'b0;
      end else if (is_ovf) begin
        quotient    <= '1;
        remainder   <= '1;
        div_by_zero <= 1'b0;
        overflow    <= 1'b1;
      end else begin
        rem_q <= dividend[DVD_W-1:DVS_W];
        shf_q <= dividend[DVS_W-1:0];
        dvs_q <= divisor;
        cnt   <= '0;
      end
    end else if (state == RUN) begin
      rem_q <= rem_nxt;
      shf_q <= {shf_q[DVS_W-2:0], q_bit};
      cnt   <= cnt + 1'b1;
      if (last_step) begin
        quotient    <= {shf_q[DVS_W-2:0], q_bit};
        remainder   <= rem_nxt;
        div_by_zero <= 1'b0;
        overflow    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_div_10by5.sv
// Randomized self-checking bench for div_10by5 against an arithmetic reference model.
module tb_div_10by5;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] dividend = '0;
  logic [4:0] divisor = '0;
  logic [4:0] quotient, remainder;
  logic       busy, done, div_by_zero, overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_10by5 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int a, input int b, output int q, output int r,
                                output int dz, output int ov, output int lat, output int bsy);
    dz = 0; ov = 0; lat = 1; bsy = 0;
    if (b == 0) begin
      q = 31; r = a % 32; dz = 1;
    end else if (a / b > 31) begin
      q = 31; r = 31; ov = 1;
    end else begin
      q = a / b; r = a % b; lat = 6; bsy = 5;
    end
  endfunction

  // Called #1 after the accepting edge; counts edges until done shows up.
  task automatic wait_done(output int lat, output int bsy, output int both);
    lat = 1; bsy = 0; both = 0;
    while (!done && lat < 20) begin
      if (busy) bsy++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy && done) both = 1;
  endtask

  task automatic check_result(input string tag, input int a, input int b,
                              input int lat, input int bsy, input int both);
    int q, r, dz, ov, elat, ebsy;
    model(a, b, q, r, dz, ov, elat, ebsy);
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".busy_cycles"}, bsy, ebsy);
    chk({tag, ".busy_and_done"}, both, 0);
    chk({tag, ".quotient"}, quotient, q);
    chk({tag, ".remainder"}, remainder, r);
    chk({tag, ".div_by_zero"}, div_by_zero, dz);
    chk({tag, ".overflow"}, overflow, ov);
  endtask

  task automatic do_op(input string tag, input int a, input int b);
    int lat, bsy, both;
    @(negedge clk);
    start = 1'b1; dividend = 10'(a); divisor = 5'(b);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bsy, both);
    check_result(tag, a, b, lat, bsy, both);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, ".quotient"}, quotient, 0);
    chk({tag, ".remainder"}, remainder, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".div_by_zero"}, div_by_zero, 0);
    chk({tag, ".overflow"}, overflow, 0);
  endtask

  initial begin
    int lat, bsy, both, saw_done;
    #12;
    check_zero_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    do_op("d100_7", 100, 7);
    do_op("d991_31", 991, 31);
    do_op("d992_31", 992, 31);
    do_op("d555_0", 555, 0);
    do_op("d0_1", 0, 1);
    do_op("d1023_31", 1023, 31);
    do_op("d31_1", 31, 1);
    do_op("d32_1", 32, 1);

    // start during RUN is ignored; start held in DONE is a back-to-back accept
    @(negedge clk);
    start = 1'b1; dividend = 10'd100; divisor = 5'd7;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 10'd50; divisor = 5'd3;
    @(posedge clk); #1 start = 1'b0;
    wait_done(lat, bsy, both);
    lat = lat + 2;
    bsy = bsy + 2;
    check_result("ign_run", 100, 7, lat, bsy, both);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(lat, bsy, both);
    check_result("b2b_done", 50, 3, lat, bsy, both);

    // reset mid-operation: outputs clear at once and no done pulse follows
    @(negedge clk);
    start = 1'b1; dividend = 10'd100; divisor = 5'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1 check_zero_outputs("rst_run");
    saw_done = 0;
    repeat (2) @(posedge clk) #1 if (done) saw_done = 1;
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk) #1 if (done) saw_done = 1;
    chk("rst_run.no_done", saw_done, 0);
    do_op("after_rst_9_4", 9, 4);

    // random operations, with occasional idle gaps between them
    for (int i = 0; i < 1500; i++) begin
      int a, b;
      a = int'($urandom_range(1023, 0));
      case ($urandom_range(3, 0))
        0:       b = 0;
        1:       b = int'($urandom_range(31, 1));
        default: b = int'($urandom_range(31, 0));
      endcase
      if ($urandom_range(3, 0) == 0) repeat ($urandom_range(3, 1)) @(posedge clk);
      do_op("rand", a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
